// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution MAC sequencer.
// IDLE wait start | CLEAR zero MAC | TAP feed KLEN taps | DRAIN MAC latency | OUT hold result | FIN done pulse
package conv_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_TAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_buf.sv
// Register array with synchronous write and asynchronous read; cleared on reset.
module conv_buf
    import conv_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  DW    = DW_DEF,
    localparam int AW    = idx_w(DEPTH)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we && (int'(waddr) < DEPTH))
            mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/conv_mac_sequencer.sv
// Walks the convolution index space, drives an external MAC and streams one result per output sample.
// Build option CONV_VALID_ONLY_EN restricts output to fully-overlapped samples n = KLEN-1..sig_len-1.
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int  KLEN    = 8,
    parameter int  SLEN    = 64,
    parameter int  DW      = DW_DEF,
    parameter int  AW      = AW_DEF,
    parameter int  MAC_LAT = 1,
    localparam int SAW     = idx_w(SLEN),
    localparam int KAW     = idx_w(KLEN),
    localparam int LW      = SAW + 1,
    localparam int NW      = idx_w(SLEN + KLEN) + 1,
    localparam int DLW     = idx_w(MAC_LAT)
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           s_wr_en,
    input  logic [SAW-1:0] s_wr_addr,
    input  logic [DW-1:0]  s_wr_data,
    input  logic           k_wr_en,
    input  logic [KAW-1:0] k_wr_addr,
    input  logic [DW-1:0]  k_wr_data,
    input  logic [LW-1:0]  sig_len,
    input  logic           start,
    output logic [DW-1:0]  mac_x,
    output logic [DW-1:0]  mac_y,
    output logic           accum_reset,
    input  logic [AW-1:0]  mac_acc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  out_data,
    output logic           busy,
    output logic           done
);

    state_t         state_q, state_d;
    logic [NW-1:0]  n_q, n_d, nlast_q, nlast_d;
    logic [KAW-1:0] k_q, k_d;
    logic [DLW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0]  len_q, len_d;
    logic           empty_q, empty_d;
    logic [DW-1:0]  x_q, x_d, y_q, y_d;
    logic           ar_q, ar_d, ov_q, ov_d, busy_q, busy_d, done_q, done_d;
    logic [AW-1:0]  od_q, od_d;

    logic [LW-1:0]    len_c;
    logic [NW-1:0]    nfirst_c, nlast_c;
    logic             none_c;
    logic signed [NW:0] sidx;
    logic             in_rng;
    logic [DW-1:0]    s_rdata, k_rdata;

    conv_buf #(.DEPTH(SLEN), .DW(DW)) u_sbuf (
        .clk(clk), .reset(reset), .we(s_wr_en && !busy_q), .waddr(s_wr_addr),
        .wdata(s_wr_data), .raddr(sidx[SAW-1:0]), .rdata(s_rdata)
    );

    conv_buf #(.DEPTH(KLEN), .DW(DW)) u_kbuf (
        .clk(clk), .reset(reset), .we(k_wr_en && !busy_q), .waddr(k_wr_addr),
        .wdata(k_wr_data), .raddr(k_d), .rdata(k_rdata)
    );

    always_comb begin
        len_c = (sig_len > LW'(SLEN)) ? LW'(SLEN) : sig_len;
`ifdef CONV_VALID_ONLY_EN
        none_c   = (NW'(len_c) < NW'(KLEN));
        nfirst_c = NW'(KLEN - 1);
        nlast_c  = NW'(len_c) - NW'(1);
`else
        none_c   = (len_c == '0);
        nfirst_c = '0;
        nlast_c  = NW'(len_c) + NW'(KLEN) - NW'(2);
`endif
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        nlast_d = nlast_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        len_d   = len_q;
        empty_d = empty_q;
        od_d    = od_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start) begin
                    len_d   = len_c;
                    n_d     = nfirst_c;
                    nlast_d = nlast_c;
                    empty_d = none_c;
                    k_d     = '0;
                    dcnt_d  = '0;
                    // An empty block still spends one busy cycle before its done pulse
                    state_d = none_c ? ST_DRAIN : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_TAP;
                k_d     = '0;
            end
            ST_TAP: begin
                if (k_q == KAW'(KLEN - 1)) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = DLW'(MAC_LAT - 1);
                end else begin
                    k_d = k_q + KAW'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == '0) begin
                    if (empty_q) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_OUT;
                        od_d    = mac_acc;
                    end
                end else begin
                    dcnt_d = dcnt_q - DLW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (n_q == nlast_q) begin
                        state_d = ST_FIN;
                    end else begin
                        n_d     = n_q + NW'(1);
                        state_d = ST_CLEAR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Sample index n-k may be negative or past the block end; both read as zero
        sidx   = $signed({1'b0, n_q}) - $signed({{(NW + 1 - KAW){1'b0}}, k_d});
        in_rng = !sidx[NW] && (sidx[NW-1:0] < NW'(len_q));

        x_d    = (state_d == ST_TAP && in_rng) ? s_rdata : '0;
        y_d    = (state_d == ST_TAP) ? k_rdata : '0;
        ar_d   = (state_d == ST_CLEAR);
        ov_d   = (state_d == ST_OUT);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            nlast_q <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            len_q   <= '0;
            empty_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ar_q    <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            nlast_q <= nlast_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
            len_q   <= len_d;
            empty_q <= empty_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ar_q    <= ar_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mac_x       = x_q;
    assign mac_y       = y_q;
    assign accum_reset = ar_q;
    assign out_valid   = ov_q;
    assign out_data    = od_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer: behavioural MAC, reference convolution queue and per-cycle output checks.
module tb_conv_mac_sequencer;
    localparam int KLEN = 8;
    localparam int SLEN = 64;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int SAW  = $clog2(SLEN);
    localparam int KAW  = $clog2(KLEN);
    localparam int LW   = SAW + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           s_wr_en, k_wr_en, start, out_ready;
    logic [SAW-1:0] s_wr_addr;
    logic [KAW-1:0] k_wr_addr;
    logic [DW-1:0]  s_wr_data, k_wr_data, mac_x, mac_y;
    logic [LW-1:0]  sig_len;
    logic           accum_reset, out_valid, busy, done;
    logic [AW-1:0]  mac_acc, out_data;

    int checks = 0;
    int failures = 0;
    int s_arr [SLEN];
    int h_arr [KLEN];
    int exp_q [$];
    int ar_cnt, done_cnt, res_cnt, nres;
    logic prev_stall = 1'b0, prev_done = 1'b0;
    logic [AW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    conv_mac_sequencer #(.KLEN(KLEN), .SLEN(SLEN), .DW(DW), .AW(AW), .MAC_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
        .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
        .sig_len(sig_len), .start(start),
        .mac_x(mac_x), .mac_y(mac_y), .accum_reset(accum_reset), .mac_acc(mac_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    // The multiply-accumulate unit being driven: one-cycle latency, wraps at AW
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            mac_acc <= '0;
        else if (accum_reset) mac_acc <= '0;
        else                  mac_acc <= mac_acc + AW'(int'($signed(mac_x)) * int'($signed(mac_y)));
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void prepare(input int len_in);
        int L = (len_in > SLEN) ? SLEN : len_in;
        int lo, hi;
`ifdef CONV_VALID_ONLY_EN
        lo = KLEN - 1;
        hi = L - 1;
`else
        lo = 0;
        hi = L + KLEN - 2;
`endif
        if (L == 0) hi = lo - 1;
        exp_q.delete();
        for (int n = lo; n <= hi; n++) begin
            int acc = 0;
            for (int k = 0; k < KLEN; k++)
                if (n - k >= 0 && n - k < L) acc += h_arr[k] * s_arr[n - k];
            exp_q.push_back(acc);
        end
        nres = exp_q.size();
    endfunction

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (accum_reset) ar_cnt++;
            if (done) begin
                done_cnt++;
                check("done_one_cycle", prev_done, 0);
            end
            if (out_valid && !busy) check("valid_while_idle", busy, 1);
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, prev_data);
            end
            if (out_valid) begin
                check("mac_idle_in_out", {mac_x, mac_y, accum_reset}, 0);
                if (out_ready) begin
                    res_cnt++;
                    if (exp_q.size() == 0) check("result_expected", exp_q.size(), 1);
                    else check("y_n", $signed(out_data), exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_done  = done;
        end
    end

    task automatic load_bufs(input int len_in);
        int L = (len_in > SLEN) ? SLEN : len_in;
        int n = (L > KLEN) ? L : KLEN;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_wr_en   = (i < L);
            s_wr_addr = SAW'(i);
            s_wr_data = DW'(s_arr[i]);
            k_wr_en   = (i < KLEN);
            k_wr_addr = KAW'(i % KLEN);
            k_wr_data = DW'(h_arr[i % KLEN]);
        end
        @(posedge clk); #1;
        s_wr_en = 1'b0;
        k_wr_en = 1'b0;
    endtask

    task automatic start_block(input int len_in);
        ar_cnt = 0; done_cnt = 0; res_cnt = 0;
        @(posedge clk); #1;
        sig_len = LW'(len_in);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode);
        int stall = 0;
        for (int c = 0; c < 6000 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            case (mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                        if (stall == 3) begin
                            check("stall_out_data", $signed(out_data), 5);
                            check("stall_mac_xy", {mac_x, mac_y, accum_reset}, 0);
                        end
                    end else begin
                        out_ready = (stall >= 5);
                    end
                end
                3: begin
                    out_ready = 1'b1;
                    start     = (c == 20);
                    s_wr_en   = (c == 20);
                    k_wr_en   = (c == 20);
                    sig_len   = LW'(3);
                    s_wr_addr = '0; s_wr_data = 8'd99;
                    k_wr_addr = '0; k_wr_data = 8'd99;
                end
                default: out_ready = 1'b1;
            endcase
        end
        repeat (3) begin
            @(posedge clk); #1;
            out_ready = 1'b1; start = 1'b0; s_wr_en = 1'b0; k_wr_en = 1'b0;
        end
        check("done_pulses", done_cnt, 1);
        check("results_left", exp_q.size(), 0);
        check("results_seen", res_cnt, nres);
        check("accum_reset_per_result", ar_cnt, nres);
    endtask

    task automatic run_block(input int len_in, input int mode);
        load_bufs(len_in);
        start_block(len_in);
        wait_done(mode);
    endtask

    task automatic randomize_data();
        foreach (s_arr[i]) s_arr[i] = int'($urandom_range(0, 255)) - 128;
        foreach (h_arr[i]) h_arr[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s_wr_en = 0; k_wr_en = 0; start = 0; out_ready = 1;
        s_wr_addr = '0; s_wr_data = '0; k_wr_addr = '0; k_wr_data = '0; sig_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, busy, done, accum_reset, mac_x, mac_y, out_data}, 0);
        @(posedge clk); #1 reset = 1'b0;

`ifndef CONV_VALID_ONLY_EN
        // Impulse kernel reproduces the signal
        foreach (s_arr[i]) s_arr[i] = 0;
        foreach (h_arr[i]) h_arr[i] = 0;
        h_arr[0] = 1; s_arr[0] = 5; s_arr[1] = -3; s_arr[2] = 7;
        prepare(3);
        check("model_t1_count", exp_q.size(), 10);
        check("model_t1_y0", exp_q[0], 5);
        check("model_t1_y1", exp_q[1], -3);
        check("model_t1_y2", exp_q[2], 7);
        check("model_t1_y3", exp_q[3], 0);
        run_block(3, 0);

        prepare(3);
        run_block(3, 2);

        foreach (s_arr[i]) s_arr[i] = -128;
        foreach (h_arr[i]) h_arr[i] = 127;
        prepare(8);
        check("model_t2_y0", exp_q[0], -16256);
        check("model_t2_y7", exp_q[7], -130048);
        run_block(8, 1);

        // Reset in the middle of output n=2
        randomize_data();
        prepare(5);
        load_bufs(5);
        start_block(5);
        out_ready = 1'b1;
        for (int c = 0; c < 200 && ar_cnt < 3; c++) begin
            @(posedge clk); #1;
        end
        check("reached_n2", ar_cnt, 3);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrun_reset_outputs", {out_valid, busy, done, accum_reset, mac_x, mac_y, out_data}, 0);
        @(posedge clk); #1 reset = 1'b0;
        prepare(7);
        run_block(7, 1);
`endif

        // Empty block: one busy cycle then done, no results
        prepare(0);
        start_block(0);
        check("empty_busy", {busy, done}, 2'b10);
        @(posedge clk); #1;
        check("empty_done", {busy, done}, 2'b01);
        @(posedge clk); #1;
        check("empty_after", {busy, done, out_valid}, 0);
        check("empty_results", res_cnt, 0);

`ifdef CONV_VALID_ONLY_EN
        foreach (h_arr[i]) h_arr[i] = 1;
        foreach (s_arr[i]) s_arr[i] = i + 1;
        prepare(10);
        check("model_valid_count", exp_q.size(), 3);
        check("model_valid_y0", exp_q[0], 36);
        check("model_valid_y1", exp_q[1], 44);
        check("model_valid_y2", exp_q[2], 52);
        run_block(10, 1);
        prepare(5);
        check("model_valid_short", exp_q.size(), 0);
        run_block(5, 0);
`endif

        // Start and buffer writes while busy are ignored
        randomize_data();
        prepare(12);
        run_block(12, 3);

        randomize_data();
        prepare(1);
        run_block(1, 1);

        randomize_data();
        prepare(100);
        run_block(100, 1);

        for (int t = 0; t < 5; t++) begin
            int len = int'($urandom_range(1, SLEN));
            randomize_data();
            prepare(len);
            run_block(len, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
